// File: rtl/rf_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file.
// Latency: grant same cycle as request; strobe one cycle later; read data/error one cycle after RdData_Valid/timeout.
// Backpressure: requests are held until granted; no grant while a transaction is in flight; RdData_Valid ignored outside READ_WAIT.
module rf_arbiter #(
    parameter int RD_TIMEOUT = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       WE0,
    input  logic       WE1,
    input  logic [3:0] ADDR0,
    input  logic [3:0] ADDR1,
    input  logic [7:0] WDATA0,
    input  logic [7:0] WDATA1,
    output logic       GNT0,
    output logic       GNT1,
    output logic [7:0] RDATA0,
    output logic [7:0] RDATA1,
    output logic       RVALID0,
    output logic       RVALID1,
    output logic       RD_ERR0,
    output logic       RD_ERR1,
    output logic       BUSY,
    output logic [3:0] Address,
    output logic       WrEn,
    output logic       RdEn,
    output logic [7:0] WrData,
    input  logic [7:0] RdData,
    input  logic       RdData_Valid
);

    localparam int CW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ_ISSUE, READ_WAIT} state_t;

    state_t        state;
    logic          last;   // requester granted most recently; 1 after reset so 0 wins first
    logic          owner;  // requester owning the in-flight transaction
    logic [CW-1:0] cnt;

    logic       gnt0_c;
    logic       gnt1_c;
    logic       sel_we;
    logic [3:0] sel_addr;
    logic [7:0] sel_wdata;

    // Grant decision: only in IDLE, never during reset, round-robin on contention
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!RST && state == IDLE) begin
            if (REQ0 && REQ1) begin
                if (last) gnt0_c = 1'b1;
                else      gnt1_c = 1'b1;
            end else if (REQ0) begin
                gnt0_c = 1'b1;
            end else if (REQ1) begin
                gnt1_c = 1'b1;
            end
        end
    end

    assign GNT0      = gnt0_c;
    assign GNT1      = gnt1_c;
    assign sel_we    = gnt1_c ? WE1    : WE0;
    assign sel_addr  = gnt1_c ? ADDR1  : ADDR0;
    assign sel_wdata = gnt1_c ? WDATA1 : WDATA0;

    // Transaction FSM with registered register-file strobes and response pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            last    <= 1'b1;
            owner   <= 1'b0;
            cnt     <= '0;
            RDATA0  <= '0;
            RDATA1  <= '0;
            RVALID0 <= 1'b0;
            RVALID1 <= 1'b0;
            RD_ERR0 <= 1'b0;
            RD_ERR1 <= 1'b0;
            BUSY    <= 1'b0;
            Address <= '0;
            WrEn    <= 1'b0;
            RdEn    <= 1'b0;
            WrData  <= '0;
        end else begin
            RVALID0 <= 1'b0;
            RVALID1 <= 1'b0;
            RD_ERR0 <= 1'b0;
            RD_ERR1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt0_c || gnt1_c) begin
                        owner   <= gnt1_c;
                        last    <= gnt1_c;
                        BUSY    <= 1'b1;
                        Address <= sel_addr;
                        if (sel_we) begin
                            WrEn   <= 1'b1;
                            WrData <= sel_wdata;
                            state  <= WRITE;
                        end else begin
                            RdEn  <= 1'b1;
                            state <= READ_ISSUE;
                        end
                    end
                end
                WRITE: begin
                    WrEn    <= 1'b0;
                    WrData  <= '0;
                    Address <= '0;
                    BUSY    <= 1'b0;
                    state   <= IDLE;
                end
                READ_ISSUE: begin
                    RdEn  <= 1'b0;
                    cnt   <= '0;
                    state <= READ_WAIT;
                end
                READ_WAIT: begin
                    // Valid data wins over a coinciding timeout
                    if (RdData_Valid) begin
                        if (owner) begin
                            RDATA1  <= RdData;
                            RVALID1 <= 1'b1;
                        end else begin
                            RDATA0  <= RdData;
                            RVALID0 <= 1'b1;
                        end
                        Address <= '0;
                        BUSY    <= 1'b0;
                        state   <= IDLE;
                    end else if (cnt == CW'(RD_TIMEOUT - 1)) begin
                        if (owner) RD_ERR1 <= 1'b1;
                        else       RD_ERR0 <= 1'b1;
                        Address <= '0;
                        BUSY    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_arbiter.sv
// Bench for rf_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_rf_arbiter;

    localparam int RD_TIMEOUT = 8;

    logic       CLK = 1'b0;
    logic       RST, REQ0, REQ1, WE0, WE1;
    logic [3:0] ADDR0, ADDR1;
    logic [7:0] WDATA0, WDATA1;
    logic       GNT0, GNT1, RVALID0, RVALID1, RD_ERR0, RD_ERR1, BUSY, WrEn, RdEn;
    logic [7:0] RDATA0, RDATA1, WrData, RdData;
    logic [3:0] Address;
    logic       RdData_Valid;

    rf_arbiter #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .RDATA0(RDATA0), .RDATA1(RDATA1),
        .RVALID0(RVALID0), .RVALID1(RVALID1), .RD_ERR0(RD_ERR0), .RD_ERR1(RD_ERR1),
        .BUSY(BUSY), .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
        .RdData(RdData), .RdData_Valid(RdData_Valid)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Transaction-level model: one outstanding access, described by its age in cycles
    bit         m_busy;
    bit         m_we;
    bit         m_own;
    bit         m_last;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    int         m_age;
    logic [7:0] m_rd [2];
    bit         m_rv [2];
    bit         m_er [2];

    int gnt_who[$];
    int gnt_cyc[$];
    int err_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_last = 1; m_own = 0; m_age = 0;
        m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        m_rv[0] = 0; m_rv[1] = 0; m_er[0] = 0; m_er[1] = 0;
    endtask

    task automatic idle_inputs();
        REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0; ADDR0 = 0; ADDR1 = 0;
        WDATA0 = 0; WDATA1 = 0; RdData = 0; RdData_Valid = 0;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model across the next edge
    task automatic step();
        bit eg0, eg1, ewr, erd, g1;
        logic [3:0] ea;
        logic [7:0] ewd;
        @(negedge CLK);
        eg0 = 0; eg1 = 0; ewr = 0; erd = 0; ea = 0; ewd = 0;
        if (!m_busy) begin
            if (!RST) begin
                if (REQ0 && REQ1) begin
                    if (m_last) eg0 = 1; else eg1 = 1;
                end else if (REQ0) eg0 = 1;
                else if (REQ1) eg1 = 1;
            end
        end else begin
            ea = m_addr;
            if (m_age == 1) begin
                if (m_we) begin ewr = 1; ewd = m_data; end
                else erd = 1;
            end
        end
        chk("GNT0", GNT0, eg0);
        chk("GNT1", GNT1, eg1);
        chk("WrEn", WrEn, ewr);
        chk("RdEn", RdEn, erd);
        chk("Address", Address, ea);
        chk("WrData", WrData, ewd);
        chk("BUSY", BUSY, m_busy);
        chk("RVALID0", RVALID0, m_rv[0]);
        chk("RVALID1", RVALID1, m_rv[1]);
        chk("RD_ERR0", RD_ERR0, m_er[0]);
        chk("RD_ERR1", RD_ERR1, m_er[1]);
        chk("RDATA0", RDATA0, m_rd[0]);
        chk("RDATA1", RDATA1, m_rd[1]);
        if (GNT0 || GNT1) begin gnt_who.push_back(GNT1 ? 1 : 0); gnt_cyc.push_back(cyc); end
        if (RD_ERR0 || RD_ERR1) err_cyc = cyc;

        m_rv[0] = 0; m_rv[1] = 0; m_er[0] = 0; m_er[1] = 0;
        if (RST) begin
            model_reset();
        end else if (!m_busy) begin
            if (eg0 || eg1) begin
                g1 = eg1;
                m_busy = 1; m_own = g1; m_last = g1; m_age = 1;
                m_we   = g1 ? WE1 : WE0;
                m_addr = g1 ? ADDR1 : ADDR0;
                m_data = g1 ? WDATA1 : WDATA0;
            end
        end else if (m_we) begin
            m_busy = 0;
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (RdData_Valid) begin
            m_rd[m_own] = RdData; m_rv[m_own] = 1; m_busy = 0;
        end else if (m_age - 2 == RD_TIMEOUT - 1) begin
            m_er[m_own] = 1; m_busy = 0;
        end else begin
            m_age++;
        end
        @(posedge CLK); #1;
        cyc++;
    endtask

    task automatic apply_reset();
        RST = 1; idle_inputs();
        step();
        step();
        RST = 0;
    endtask

    initial begin
        int g;
        RST = 1; idle_inputs();
        model_reset();
        @(posedge CLK); #1;
        apply_reset();

        // Single write by requester 0
        REQ0 = 1; WE0 = 1; ADDR0 = 4'd3; WDATA0 = 8'h5A;
        step();
        idle_inputs();
        step(); step(); step();

        // Single read by requester 1 answered at T+2
        REQ1 = 1; WE1 = 0; ADDR1 = 4'd2;
        step();
        idle_inputs();
        step();
        RdData = 8'hC3; RdData_Valid = 1;
        step();
        idle_inputs();
        step(); step();
        chk("rdata1_c3", RDATA1, 8'hC3);

        // Continuous contention of two writers right after reset
        apply_reset();
        gnt_who.delete(); gnt_cyc.delete();
        REQ0 = 1; REQ1 = 1; WE0 = 1; WE1 = 1; WDATA0 = 8'h11; WDATA1 = 8'h22;
        ADDR0 = 4'd1; ADDR1 = 4'd9;
        for (int i = 0; i < 8; i++) step();
        idle_inputs();
        step();
        chk("rr_count", gnt_who.size(), 4);
        for (int i = 0; i < 4 && i < gnt_who.size(); i++) begin
            chk("rr_order", gnt_who[i], i % 2);
            if (i > 0) chk("rr_spacing", gnt_cyc[i] - gnt_cyc[i-1], 2);
        end

        // Read that never gets data: error pulse RD_TIMEOUT cycles after READ_WAIT entry
        gnt_cyc.delete(); err_cyc = -1;
        REQ0 = 1; WE0 = 0; ADDR0 = 4'd7;
        step();
        idle_inputs();
        for (int i = 0; i < RD_TIMEOUT + 4; i++) step();
        g = (gnt_cyc.size() > 0) ? gnt_cyc[0] : -100;
        chk("timeout_latency", err_cyc - g, RD_TIMEOUT + 2);
        chk("timeout_rdata0", RDATA0, 8'h00);

        // Reset during READ_WAIT coinciding with RdData_Valid
        REQ1 = 1; WE1 = 0; ADDR1 = 4'd5;
        step();
        idle_inputs();
        step(); step();
        RST = 1; RdData = 8'hEE; RdData_Valid = 1;
        step();
        RST = 0; idle_inputs();
        step(); step();

        // Requester 0 pulses only while requester 1's write is in progress
        REQ1 = 1; WE1 = 1; ADDR1 = 4'd4; WDATA1 = 8'h77;
        step();
        idle_inputs();
        REQ0 = 1; WE0 = 1; ADDR0 = 4'd8; WDATA0 = 8'h99;
        step();
        idle_inputs();
        step(); step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            RST          = ($urandom_range(0, 299) == 0);
            REQ0         = ($urandom_range(0, 2) != 0);
            REQ1         = ($urandom_range(0, 2) != 0);
            WE0          = $urandom_range(0, 1);
            WE1          = $urandom_range(0, 1);
            ADDR0        = 4'($urandom);
            ADDR1        = 4'($urandom);
            WDATA0       = 8'($urandom);
            WDATA1       = 8'($urandom);
            RdData       = 8'($urandom);
            RdData_Valid = ($urandom_range(0, 5) == 0);
            step();
        end
        RST = 0; idle_inputs();
        for (int i = 0; i < RD_TIMEOUT + 4; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_arbiter.md
RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 Parameter RD_TIMEOUT, default 8, is the maximum number of READ_WAIT cycles spent waiting for RdData_Valid before the read is aborted.
REQ-002 CLK  input  1  single system clock; all state changes on the rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 REQ0/REQ1  input  1  requester 0/1 access request, level, held until granted.
REQ-005 WE0/WE1  input  1  1 = write, 0 = read; sampled in the grant cycle.
REQ-006 ADDR0/ADDR1  input  4  register address; sampled in the grant cycle.
REQ-007 WDATA0/WDATA1  input  8  write data; sampled in the grant cycle.
REQ-008 GNT0/GNT1  output  1  one-cycle pulse; request accepted and fields sampled this cycle.
REQ-009 RDATA0/RDATA1  output  8  last read data returned to that requester; held until its next successful read.
REQ-010 RVALID0/RVALID1  output  1  one-cycle pulse; RDATAx updated this cycle.
REQ-011 RD_ERR0/RD_ERR1  output  1  one-cycle pulse; read aborted on timeout.
REQ-012 BUSY  output  1  high whenever the state is not IDLE.
REQ-013 Address  output  4  register file address.
REQ-014 WrEn  output  1  register file write strobe.
REQ-015 RdEn  output  1  register file read strobe.
REQ-016 WrData  output  8  register file write data.
REQ-017 RdData  input  8  register file read data.
REQ-018 RdData_Valid  input  1  register file read data valid.

Function
REQ-019 The FSM SHALL have four states, IDLE, WRITE, READ_ISSUE and READ_WAIT, and SHALL reset to IDLE.
REQ-020 In IDLE with exactly one REQx high, the block SHALL assert GNTx combinationally in that cycle, latch WEx/ADDRx/WDATAx, and move to WRITE if WEx=1, else READ_ISSUE.
REQ-021 In IDLE with REQ0 and REQ1 both high, the block SHALL grant the requester not granted last (round-robin pointer); after reset the pointer SHALL favour requester 0.
REQ-022 The round-robin pointer SHALL update only on a grant.
REQ-023 At most one GNT SHALL be high in any cycle, and no GNT SHALL be asserted outside IDLE.
REQ-024 WRITE SHALL last exactly one cycle, driving WrEn=1, Address=latched address and WrData=latched data, then return to IDLE.
REQ-025 READ_ISSUE SHALL last exactly one cycle, driving RdEn=1 and Address=latched address, then enter READ_WAIT with the timeout counter cleared.
REQ-026 In READ_WAIT, Address SHALL hold the latched address, RdEn SHALL be 0, and the counter SHALL increment every cycle.
REQ-027 In READ_WAIT with RdData_Valid=1, the block SHALL register RdData into RDATAx of the owning requester, pulse RVALIDx in the following cycle, and return to IDLE.
REQ-028 If the counter reaches RD_TIMEOUT-1 in READ_WAIT without RdData_Valid, the block SHALL pulse RD_ERRx of the owner in the next cycle, leave RDATAx unchanged, and return to IDLE.
REQ-029 If RdData_Valid and the timeout condition coincide, valid data SHALL win and no error SHALL be flagged.
REQ-030 RdData_Valid SHALL be ignored in IDLE, WRITE and READ_ISSUE.
REQ-031 Outside WRITE and READ_ISSUE, WrEn and RdEn SHALL be 0; WrData SHALL be 0 outside WRITE; Address SHALL be 0 in IDLE.
REQ-032 Latency: write grant at cycle T gives WrEn at T+1; read grant at T gives RdEn at T+1, and RdData_Valid at T+2 gives RVALID at T+3.
REQ-033 Throughput: one write per 2 cycles; the next grant is possible in the IDLE cycle following WRITE.
REQ-034 A REQx dropped before its grant SHALL be discarded with no side effects.
REQ-035 A requester not currently owning the register file SHALL still receive its own RVALID/RD_ERR pulse, routed by the latched owner ID.

Reset
REQ-036 While RST=1 at a clock edge, the block SHALL set state=IDLE, pointer favouring 0, counter=0, GNT/RVALID/RD_ERR/BUSY=0, RDATA0=RDATA1=0, and Address/WrData/WrEn/RdEn=0.
REQ-037 RST asserted mid-transaction SHALL abort the transaction with no RVALID or RD_ERR pulse, and RST SHALL take precedence over all other inputs.

Verification
REQ-038 REQ0=1, WE0=1, ADDR0=3, WDATA0=8'h5A -> GNT0 at T; WrEn=1, Address=3, WrData=8'h5A at T+1; BUSY=0 at T+2.
REQ-039 REQ1 read of ADDR1=2, with RdData=8'hC3 and RdData_Valid at T+2 -> RdEn at T+1; RVALID1=1 and RDATA1=8'hC3 at T+3; RVALID0 stays 0.
REQ-040 REQ0 and REQ1 held continuously as writes after reset -> grants in the order 0,1,0,1, every other cycle.
REQ-041 Read with RdData_Valid never asserted and RD_TIMEOUT=8 -> RD_ERR pulse 8 cycles after entering READ_WAIT; RDATA unchanged; FSM returns to IDLE.
REQ-042 RST=1 in READ_WAIT with RdData_Valid high the same cycle -> no RVALID pulse; all outputs 0 in the next cycle.
REQ-043 REQ0 pulsed for one cycle while in WRITE serving requester 1 -> no GNT0 and no register file access.
